// File: rtl/rr_arbiter_hold_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter_hold_pkg                                                  |
// | Shared state encoding, default sizing and one-hot helper.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rr_arbiter_hold_pkg;

  localparam int DEF_M        = 8;
  localparam int DEF_N        = 3;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_HOLD_MAX = 16;
  localparam int MAX_M        = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Callers cast the result down to their own requester count.
  function automatic logic [MAX_M-1:0] onehot(input int unsigned idx);
    return MAX_M'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_hold_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter_hold_if                                                   |
// | Request/grant bundle between requesters and the arbiter.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rr_arbiter_hold_if #(
  parameter int M = 8,
  parameter int N = 3
);
  logic         en;
  logic [M-1:0] req;
  logic [M-1:0] gnt;
  logic [N-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  // master: the arbiter, which owns the grant side
  modport master (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

  // slave: the requesting units
  modport slave (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_hold_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin picker: masked then unmasked lowest-index. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int M = 8,
  parameter int N = 3
) (
  input  logic [M-1:0] req,
  input  logic [N-1:0] last_idx,
  output logic [N-1:0] winner,
  output logic         any
);

  logic [M-1:0] w_mask;
  logic [M-1:0] w_masked;
  logic [N-1:0] w_masked_idx;
  logic [N-1:0] w_raw_idx;
  logic         w_masked_any;

  generate
    for (genvar i = 0; i < M; i++) begin : g_mask
      assign w_mask[i] = (32'(i) > 32'(last_idx));
    end
  endgenerate

  assign w_masked = req & w_mask;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    w_masked_idx = '0;
    w_masked_any = 1'b0;
    w_raw_idx    = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_masked_idx = N'(i);
        w_masked_any = 1'b1;
      end
      if (req[i]) begin
        w_raw_idx = N'(i);
      end
    end
  end

  assign winner = w_masked_any ? w_masked_idx : w_raw_idx;
  assign any    = |req;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter_hold                                                      |
// | Round-robin arbiter holding each grant until release or timeout.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter_hold
  import rr_arbiter_hold_pkg::*;
#(
  parameter int M        = DEF_M,
  parameter int N        = DEF_N,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter_hold_if.master  bus
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] C_HOLD_SAT  = CNT_W'(HOLD_MAX);

  state_t             r_state,    w_state_nxt;
  logic [M-1:0]       r_gnt,      w_gnt_nxt;
  logic [N-1:0]       r_gnt_idx,  w_gnt_idx_nxt;
  logic [N-1:0]       r_last_idx, w_last_idx_nxt;
  logic               r_valid,    w_valid_nxt;
  logic               r_timeout,  w_timeout_nxt;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [N-1:0]       w_win;
  logic               w_any;
  logic               w_drop;
  logic               w_tmo_hit;

  rr_pick #(.M(M), .N(N)) u_pick (
    .req      (bus.req),
    .last_idx (r_last_idx),
    .winner   (w_win),
    .any      (w_any)
  );

  assign w_drop    = !bus.req[r_gnt_idx];
  assign w_tmo_hit = (HOLD_MAX != 0) && (r_hold_cnt == C_HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_last_idx <= N'(M - 1);
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_idx_nxt = r_last_idx;
    w_valid_nxt    = r_valid;
    w_timeout_nxt  = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (bus.en && w_any) begin
          w_state_nxt    = BUSY;
          w_gnt_nxt      = M'(onehot(32'(w_win)));
          w_gnt_idx_nxt  = w_win;
          w_last_idx_nxt = w_win;
          w_valid_nxt    = 1'b1;
          w_hold_cnt_nxt = '0;
        end
      end
      BUSY: begin
        if (w_drop || w_tmo_hit) begin
          // A simultaneous request drop counts as a normal release.
          w_state_nxt    = IDLE;
          w_gnt_nxt      = '0;
          w_valid_nxt    = 1'b0;
          w_timeout_nxt  = !w_drop;
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt != C_HOLD_SAT) begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_valid;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire
